// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, half-bit start qualification, centre sampling.
// Define UART_RX_PARITY_EN for 8E1 frames; a parity mismatch is reported as a framing error.
module uart_rx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state, state_next;
  logic            rxd_meta, rxd_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            counting, tick;
  logic            load_half, clr_idx, inc_idx, shift;
  logic            set_valid, set_ferr, frame_ok;
`ifdef UART_RX_PARITY_EN
  logic            parity_err, parity_sample;
`endif

  // The counter only runs while a frame is in flight; IDLE and BREAK just watch the line.
  assign counting = (state == START) || (state == DATA) || (state == STOP)
`ifdef UART_RX_PARITY_EN
                    || (state == PARITY)
`endif
                    ;
  assign tick = counting && (cnt == '0);

`ifdef UART_RX_PARITY_EN
  assign frame_ok = rxd_s && !parity_err;
`else
  assign frame_ok = rxd_s;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    clr_idx    = 1'b0;
    inc_idx    = 1'b0;
    shift      = 1'b0;
    set_valid  = 1'b0;
    set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_next = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (!rxd_s) begin
            state_next = DATA;
            clr_idx    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            inc_idx = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          parity_sample = 1'b1;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          set_valid = frame_ok;
          set_ferr  = !frame_ok;
          // A low stop bit means the line may be held in break; wait for it to recover.
          state_next = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta      <= 1'b1;
      rxd_s         <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      rxd_meta      <= rxd;
      rxd_s         <= rxd_meta;
      state         <= state_next;
      valid         <= set_valid;
      framing_error <= set_ferr;

      if (load_half)     cnt <= HALF_RELOAD;
      else if (tick)     cnt <= FULL_RELOAD;
      else if (counting) cnt <= cnt - CW'(1);

      if (clr_idx)      bit_idx <= '0;
      else if (inc_idx) bit_idx <= bit_idx + 3'd1;

      // Shifting in at the MSB leaves bit 0 of the frame in shreg[0] after eight samples.
      if (shift)     shreg <= {rxd_s, shreg[7:1]};
      if (set_valid) data  <= shreg;
`ifdef UART_RX_PARITY_EN
      if (parity_sample) parity_err <= (^shreg) ^ rxd_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx;

  localparam int CPB = 8;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   overlap = 0;
  ev_t  ev_q[$];
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (valid)                  ev_q.push_back('{1'b0, data, cyc});
    if (framing_error)          ev_q.push_back('{1'b1, data, cyc});
    if (valid && framing_error) overlap++;
  end

  task automatic drive(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One frame on the line; par_ok chooses correct or inverted even parity when parity is built in.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            output int start_cyc);
    start_cyc = cyc;
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
`ifdef UART_RX_PARITY_EN
    drive(par_ok ? ^b : ~^b);
`endif
    drive(stop_ok);
  endtask

  function automatic bit frame_good(input bit stop_ok, input bit par_ok);
`ifdef UART_RX_PARITY_EN
    return stop_ok && par_ok;
`else
    return stop_ok;
`endif
  endfunction

  task automatic expect_one_byte(input string name, input logic [7:0] b);
    checks++;
    if (ev_q.size() != 1) begin
      errors++;
      $display("FAIL %s count: got %0d strobes, expected 1", name, ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].err !== 1'b0 || ev_q[0].d !== b) begin
        errors++;
        $display("FAIL %s byte: got err=%0b data=%02h, expected err=0 data=%02h",
                 name, ev_q[0].err, ev_q[0].d, b);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data !== 8'h00 || valid !== 1'b0 || framing_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got data=%02h valid=%0b ferr=%0b, expected 00 0 0",
               data, valid, framing_error);
    end
    ev_q.delete();
    idle(200);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d strobes, expected 0", ev_q.size());
    end
  endtask

  task automatic test_single;
    int s, lat;
    ev_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, s);
    idle(2 * CPB);
    expect_one_byte("single", 8'hA5);
    if (ev_q.size() == 1) begin
      // Nominal centre-of-stop latency plus synchronizer and output register delay.
`ifdef UART_RX_PARITY_EN
      lat = ev_q[0].cyc - s - CPB;
`else
      lat = ev_q[0].cyc - s;
`endif
      checks++;
      if (lat < 77 || lat > 80) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles, expected 77..80", lat);
      end
    end
    idle(100);
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got data=%02h, expected a5", data);
    end
    last_byte = 8'hA5;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    int s;
    bytes = '{8'h00, 8'hFF, 8'h55};
    ev_q.delete();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 1'b1, s);
    idle(2 * CPB);
    checks++;
    if (ev_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes, expected 3", ev_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_q[i].err !== 1'b0 || ev_q[i].d !== bytes[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d: got err=%0b data=%02h, expected err=0 data=%02h",
                   i, ev_q[i].err, ev_q[i].d, bytes[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (ev_q[i].cyc - ev_q[i-1].cyc < 10 * CPB - 1 + (`ifdef UART_RX_PARITY_EN CPB `else 0 `endif)
            || ev_q[i].cyc - ev_q[i-1].cyc > 10 * CPB + 1 + (`ifdef UART_RX_PARITY_EN CPB `else 0 `endif)) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, expected one frame time +/-1",
                   i, ev_q[i].cyc - ev_q[i-1].cyc);
        end
      end
    end
    last_byte = 8'h55;
  endtask

  task automatic test_glitch;
    int s;
    ev_q.delete();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CPB);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_quiet: got %0d strobes, expected 0", ev_q.size());
    end
    send_frame(8'h3C, 1'b1, 1'b1, s);
    idle(2 * CPB);
    expect_one_byte("glitch_next", 8'h3C);
    last_byte = 8'h3C;
  endtask

  task automatic test_framing;
    int s;
    ev_q.delete();
    send_frame(8'h81, 1'b0, 1'b1, s);
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    idle(2 * CPB);
    checks++;
    if (ev_q.size() != 1 || ev_q[0].err !== 1'b1) begin
      errors++;
      $display("FAIL framing_strobe: got %0d strobes (first err=%0b), expected one framing_error",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0].err : 1'b0);
    end
    checks++;
    if (data !== last_byte) begin
      errors++;
      $display("FAIL framing_data: got data=%02h, expected unchanged %02h", data, last_byte);
    end
    ev_q.delete();
    send_frame(8'h42, 1'b1, 1'b1, s);
    idle(2 * CPB);
    expect_one_byte("framing_next", 8'h42);
    last_byte = 8'h42;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int s;
    ev_q.delete();
    send_frame(8'h07, 1'b1, 1'b1, s);
    idle(2 * CPB);
    expect_one_byte("parity_good", 8'h07);
    last_byte = 8'h07;
    ev_q.delete();
    send_frame(8'h07, 1'b1, 1'b0, s);
    idle(2 * CPB);
    checks++;
    if (ev_q.size() != 1 || ev_q[0].err !== 1'b1 || data !== 8'h07) begin
      errors++;
      $display("FAIL parity_bad: got %0d strobes data=%02h, expected one framing_error data=07",
               ev_q.size(), data);
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    int s;
    logic [7:0] b;
    b = 8'hC3;
    ev_q.delete();
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(b[i]);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(12 * CPB);
    checks++;
    if (ev_q.size() != 0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %0d strobes data=%02h, expected 0 strobes data=00",
               ev_q.size(), data);
    end
    send_frame(8'h99, 1'b1, 1'b1, s);
    idle(2 * CPB);
    expect_one_byte("reset_mid_next", 8'h99);
    last_byte = 8'h99;
  endtask

  task automatic test_random;
    ev_t exp_q[$];
    int  s;
    ev_q.delete();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      bit stop_ok, par_ok;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = ($urandom_range(0, 5) != 0);
      send_frame(b, stop_ok, par_ok, s);
      if (frame_good(stop_ok, par_ok)) begin
        last_byte = b;
        exp_q.push_back('{1'b0, b, 0});
      end else begin
        exp_q.push_back('{1'b1, last_byte, 0});
      end
      if (!stop_ok) begin
        rxd = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge clk);
        idle($urandom_range(1, CPB));
      end else begin
        idle($urandom_range(0, 2 * CPB));
      end
    end
    idle(2 * CPB);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d strobes, expected %0d", ev_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (ev_q[i].err !== exp_q[i].err || ev_q[i].d !== exp_q[i].d) begin
          errors++;
          $display("FAIL random_frame%0d: got err=%0b data=%02h, expected err=%0b data=%02h",
                   i, ev_q[i].err, ev_q[i].d, exp_q[i].err, exp_q[i].d);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_reset_mid_frame;
    test_random;
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d cycles with valid and framing_error, expected 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
